// File: rtl/mem_resp_pkg.sv
// Shared types and geometry for the line-granular backing-memory responder.
package mem_resp_pkg;

  localparam int unsigned B             = 64;
  localparam int unsigned ADDR_BITS     = 64;
  localparam int unsigned DATA_BITS     = B * 8;
  localparam int unsigned OFF_BITS      = $clog2(B);
  localparam int unsigned DEF_NUM_LINES = 1024;
  localparam int unsigned IDX_BITS      = $clog2(DEF_NUM_LINES);

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic                 we;
    logic [DATA_BITS-1:0] data;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Clear the byte-offset bits so every queued address names a whole line
  function automatic logic [ADDR_BITS-1:0] line_align(input logic [ADDR_BITS-1:0] a);
    return a & ~ADDR_BITS'(B - 1);
  endfunction

endpackage

// File: rtl/req_fifo.sv
// In-order request queue; caller never pushes when full or pops when empty.
module req_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  // Entry storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/mem_line_responder.sv
// DRAM-side line responder: queues line reads/writes and services each after LAT cycles.
module mem_line_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned NUM_LINES = DEF_NUM_LINES,
  parameter int unsigned LAT       = 4,
  parameter int unsigned QDEPTH    = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_N_in,
  input  logic                 hc_valid_in,
  output logic                 hc_ready_out,
  input  logic [ADDR_BITS-1:0] hc_addr_in,
  input  logic                 hc_we_in,
  input  logic [DATA_BITS-1:0] hc_value_in,
  output logic                 hc_valid_out,
  input  logic                 hc_ready_in,
  output logic [ADDR_BITS-1:0] hc_addr_out,
  output logic [DATA_BITS-1:0] hc_value_out,
  output logic                 err_out,
  output logic [31:0]          rd_count_out,
  output logic [31:0]          wr_count_out
);

  localparam int unsigned IW   = $clog2(NUM_LINES);
  localparam int unsigned IFW  = ADDR_BITS - OFF_BITS;
  localparam int unsigned CNTW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int unsigned QCW  = $clog2(QDEPTH) + 1;

  mem_req_t       push_req;
  mem_req_t       q_head;
  logic           q_full;
  logic           q_empty;
  logic [QCW-1:0] q_count;
  logic [QCW-1:0] count_nxt;
  logic           push_c;
  logic           pop_c;

  state_t               state_q, state_n;
  logic [CNTW-1:0]      cnt_q, cnt_n;
  mem_req_t             req_q, req_n;
  logic                 valid_q, valid_n;
  logic [ADDR_BITS-1:0] addr_q, addr_n;
  logic [DATA_BITS-1:0] value_q, value_n;
  logic                 err_q, err_n;
  logic [31:0]          rd_q, rd_n;
  logic [31:0]          wr_q, wr_n;
  logic                 ready_q;

  logic [DATA_BITS-1:0] storage [NUM_LINES];
  logic [IFW-1:0]       idx_full_c;
  logic [IW-1:0]        idx_c;
  logic                 in_range_c;
  logic [DATA_BITS-1:0] line_c;
  logic                 mem_we_c;

  assign push_c        = hc_valid_in && ready_q && !q_full;
  assign push_req.addr = line_align(hc_addr_in);
  assign push_req.we   = hc_we_in;
  assign push_req.data = hc_value_in;

  req_fifo #(
    .W     ($bits(mem_req_t)),
    .DEPTH (QDEPTH)
  ) u_req_fifo (
    .clk   (clk_in),
    .rst_n (rst_N_in),
    .push  (push_c),
    .pop   (pop_c),
    .din   (push_req),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign count_nxt  = q_count + QCW'(push_c) - QCW'(pop_c);
  assign idx_full_c = req_q.addr[ADDR_BITS-1:OFF_BITS];
  assign idx_c      = idx_full_c[IW-1:0];
  assign in_range_c = (idx_full_c < IFW'(NUM_LINES));
  assign line_c     = storage[idx_c];

  // Next-state and output decode for the service FSM
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    req_n    = req_q;
    valid_n  = valid_q;
    addr_n   = addr_q;
    value_n  = value_q;
    err_n    = 1'b0;
    rd_n     = rd_q;
    wr_n     = wr_q;
    pop_c    = 1'b0;
    mem_we_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (!q_empty) begin
          pop_c   = 1'b1;
          req_n   = q_head;
          cnt_n   = CNTW'(LAT - 1);
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CNTW'(1);
        end else if (req_q.we) begin
          mem_we_c = in_range_c;
          wr_n     = wr_q + 32'd1;
          err_n    = !in_range_c;
          state_n  = IDLE;
        end else begin
          value_n  = in_range_c ? line_c : '0;
          addr_n   = req_q.addr;
          valid_n  = 1'b1;
          rd_n     = rd_q + 32'd1;
          err_n    = !in_range_c;
          state_n  = RESP;
        end
      end
      RESP: begin
        if (hc_ready_in) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM, working registers and registered outputs
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      value_q <= '0;
      err_q   <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      req_q   <= req_n;
      valid_q <= valid_n;
      addr_q  <= addr_n;
      value_q <= value_n;
      err_q   <= err_n;
      rd_q    <= rd_n;
      wr_q    <= wr_n;
      ready_q <= (count_nxt < QCW'(QDEPTH));
    end
  end

  // Line storage survives reset
  always_ff @(posedge clk_in) begin
    if (mem_we_c) storage[idx_c] <= req_q.data;
  end

  assign hc_ready_out = ready_q;
  assign hc_valid_out = valid_q;
  assign hc_addr_out  = addr_q;
  assign hc_value_out = value_q;
  assign err_out      = err_q;
  assign rd_count_out = rd_q;
  assign wr_count_out = wr_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder (default geometry, LAT=4, QDEPTH=2).
module tb_mem_line_responder;

  localparam int unsigned NL  = 1024;
  localparam int unsigned LBY = 64;

  logic         clk_in = 1'b0;
  logic         rst_N_in;
  logic         hc_valid_in;
  logic         hc_ready_out;
  logic [63:0]  hc_addr_in;
  logic         hc_we_in;
  logic [511:0] hc_value_in;
  logic         hc_valid_out;
  logic         hc_ready_in;
  logic [63:0]  hc_addr_out;
  logic [511:0] hc_value_out;
  logic         err_out;
  logic [31:0]  rd_count_out;
  logic [31:0]  wr_count_out;

  typedef struct {
    logic [63:0]  addr;
    logic [511:0] data;
  } exp_t;

  exp_t         sb [$];
  logic [511:0] model [int unsigned];
  int n_cmp = 0;
  int n_bad = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  int exp_err = 0;
  int err_seen = 0;

  logic [511:0] pa5, p11, p5a, pc3, p3c;

  always #5 clk_in = ~clk_in;

  mem_line_responder dut (
    .clk_in       (clk_in),
    .rst_N_in     (rst_N_in),
    .hc_valid_in  (hc_valid_in),
    .hc_ready_out (hc_ready_out),
    .hc_addr_in   (hc_addr_in),
    .hc_we_in     (hc_we_in),
    .hc_value_in  (hc_value_in),
    .hc_valid_out (hc_valid_out),
    .hc_ready_in  (hc_ready_in),
    .hc_addr_out  (hc_addr_out),
    .hc_value_out (hc_value_out),
    .err_out      (err_out),
    .rd_count_out (rd_count_out),
    .wr_count_out (wr_count_out)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one request, recording its expected effect, and hold it until accepted
  task automatic send(input logic [63:0] addr, input logic we, input logic [511:0] data);
    exp_t        e;
    int unsigned idx;
    bit          inr;
    int          guard;
    inr = ((addr >> 6) < 64'(NL));
    idx = inr ? 32'(addr >> 6) : 0;
    if (we) begin
      exp_wr++;
      if (inr) model[idx] = data;
    end else begin
      exp_rd++;
      e.addr = addr & ~64'(LBY - 1);
      e.data = (inr && model.exists(idx)) ? model[idx] : '0;
      sb.push_back(e);
    end
    if (!inr) exp_err++;
    hc_addr_in  = addr;
    hc_we_in    = we;
    hc_value_in = data;
    hc_valid_in = 1'b1;
    guard = 0;
    forever begin
      @(negedge clk_in);
      if (hc_ready_out) break;
      guard++;
      if (guard > 500) begin
        check("send_timeout", 512'(hc_ready_out), 512'(1));
        hc_valid_in = 1'b0;
        return;
      end
    end
    @(posedge clk_in);
    #1 hc_valid_in = 1'b0;
  endtask

  // Wait until every issued request has been serviced and consumed
  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!(rd_count_out == 32'(exp_rd) && wr_count_out == 32'(exp_wr) && sb.size() == 0)) begin
      @(negedge clk_in);
      guard++;
      if (guard > 2000) begin
        check("idle_timeout", 512'(rd_count_out), 512'(exp_rd));
        return;
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int guard;
    guard = 0;
    while (!hc_valid_out) begin
      @(posedge clk_in);
      #1;
      guard++;
      if (guard > 100) begin
        check(tag, 512'(hc_valid_out), 512'(1));
        return;
      end
    end
  endtask

  // Response monitor: compare each consumed response against the scoreboard head
  always @(negedge clk_in) begin
    if (rst_N_in) begin
      if (err_out) err_seen++;
      if (hc_valid_out && hc_ready_in) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 512'(hc_valid_out), 512'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_addr", 512'(hc_addr_out), 512'(e.addr));
          check("resp_data", hc_value_out, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    pa5 = {64{8'hA5}};
    p11 = {64{8'h11}};
    p5a = {64{8'h5A}};
    pc3 = {64{8'hC3}};
    p3c = {64{8'h3C}};
    rst_N_in    = 1'b0;
    hc_valid_in = 1'b0;
    hc_addr_in  = '0;
    hc_we_in    = 1'b0;
    hc_value_in = '0;
    hc_ready_in = 1'b1;

    repeat (3) @(posedge clk_in);
    #1;
    check("reset_ready", 512'(hc_ready_out), 512'(0));
    check("reset_valid", 512'(hc_valid_out), 512'(0));
    check("reset_err",   512'(err_out), 512'(0));
    check("reset_rd",    512'(rd_count_out), 512'(0));
    check("reset_wr",    512'(wr_count_out), 512'(0));
    check("reset_addr",  512'(hc_addr_out), 512'(0));
    check("reset_value", hc_value_out, 512'(0));
    @(negedge clk_in) rst_N_in = 1'b1;
    @(posedge clk_in);
    #1 check("ready_after_reset", 512'(hc_ready_out), 512'(1));

    // Write then read with latency measurement
    send(64'h40, 1'b1, pa5);
    wait_idle();
    send(64'h40, 1'b0, '0);
    lat = 0;
    do begin
      @(posedge clk_in);
      #1 lat++;
    end while (!hc_valid_out && lat < 50);
    check("read_latency", 512'(lat), 512'(5));
    wait_idle();
    check("wr_count_1", 512'(wr_count_out), 512'(1));
    check("rd_count_1", 512'(rd_count_out), 512'(1));

    // Unaligned read returns the aligned line
    send(64'h47, 1'b0, '0);
    wait_idle();

    // Backpressure holds the response stable
    hc_ready_in = 1'b0;
    send(64'h40, 1'b0, '0);
    wait_valid("bp_wait_valid");
    repeat (10) begin
      @(posedge clk_in);
      #1;
      check("bp_valid", 512'(hc_valid_out), 512'(1));
      check("bp_addr",  512'(hc_addr_out), 512'(64'h40));
      check("bp_data",  hc_value_out, pa5);
    end
    hc_ready_in = 1'b1;
    @(posedge clk_in);
    #1 check("bp_release", 512'(hc_valid_out), 512'(0));
    wait_idle();

    // Queue full behind a stalled response; order preserved
    send(64'h80, 1'b1, p5a);
    send(64'hC0, 1'b1, pc3);
    send(64'h00, 1'b1, p11);
    wait_idle();
    hc_ready_in = 1'b0;
    send(64'h40, 1'b0, '0);
    wait_valid("full_wait_valid");
    send(64'h80, 1'b0, '0);
    send(64'hC0, 1'b0, '0);
    check("full_ready", 512'(hc_ready_out), 512'(0));
    fork
      send(64'h00, 1'b0, '0);
    join_none
    repeat (5) @(posedge clk_in);
    #1 check("full_hold", 512'(hc_ready_out), 512'(0));
    hc_ready_in = 1'b1;
    wait_idle();
    check("rd_count_7", 512'(rd_count_out), 512'(7));

    // Out-of-range read and dropped write; line 0 must not be aliased
    send(64'(NL * LBY), 1'b0, '0);
    wait_idle();
    check("oor_err_rd", 512'(err_seen), 512'(exp_err));
    send(64'(NL * LBY), 1'b1, p3c);
    wait_idle();
    check("oor_wr_count", 512'(wr_count_out), 512'(5));
    check("oor_err_wr", 512'(err_seen), 512'(exp_err));
    send(64'(NL * LBY), 1'b0, '0);
    send(64'h00, 1'b0, '0);
    wait_idle();
    check("oor_err_total", 512'(err_seen), 512'(3));

    // Reset during RESP drops the response but keeps storage
    hc_ready_in = 1'b0;
    send(64'h40, 1'b0, '0);
    wait_valid("rst_wait_valid");
    @(posedge clk_in);
    #1 rst_N_in = 1'b0;
    #1;
    check("rst_valid", 512'(hc_valid_out), 512'(0));
    check("rst_ready", 512'(hc_ready_out), 512'(0));
    check("rst_rd",    512'(rd_count_out), 512'(0));
    check("rst_wr",    512'(wr_count_out), 512'(0));
    sb.delete();
    exp_rd = 0;
    exp_wr = 0;
    exp_err = 0;
    err_seen = 0;
    hc_ready_in = 1'b1;
    @(negedge clk_in) rst_N_in = 1'b1;
    send(64'h40, 1'b0, '0);
    wait_idle();
    check("post_rst_rd", 512'(rd_count_out), 512'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
